// File: rtl/ckpt_free_list_allocator_if.sv
// Request/grant, retire-clear and checkpoint signals between rename/retire/branch logic and the free-list allocator.
interface ckpt_free_list_allocator_if #(
    parameter int NUM_RESOURCES = 64,
    parameter int NUM_REQUESTS  = 3,
    parameter int NUM_CKPTS     = 4
);
    localparam int IDX_W  = $clog2(NUM_RESOURCES);
    localparam int CKPT_W = (NUM_CKPTS > 1) ? $clog2(NUM_CKPTS) : 1;

    logic [NUM_REQUESTS-1:0]       req;
    logic [NUM_RESOURCES-1:0]      clear;
    logic                          ckpt_save;
    logic [CKPT_W-1:0]             ckpt_save_id;
    logic                          ckpt_restore;
    logic [CKPT_W-1:0]             ckpt_restore_id;
    logic [NUM_REQUESTS-1:0]       grant_valid;
    logic [NUM_REQUESTS*IDX_W-1:0] grant_idx;
    logic                          stall;
    logic [IDX_W:0]                free_count;

    modport master (
        output req, clear, ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
        input  grant_valid, grant_idx, stall, free_count
    );

    modport slave (
        input  req, clear, ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
        output grant_valid, grant_idx, stall, free_count
    );
endinterface

// File: rtl/ckpt_free_list_allocator.sv
// All-or-nothing multi-port free-list allocator with idempotent clears and
// branch checkpoints of the free mask that restore in a single cycle.
module ckpt_free_list_allocator #(
    parameter int                       NUM_RESOURCES      = 64,
    parameter int                       NUM_REQUESTS       = 3,
    parameter int                       NUM_CKPTS          = 4,
    parameter logic [NUM_RESOURCES-1:0] INITIAL_AVAIL_MASK = '1
) (
    input  logic                       clock,
    input  logic                       reset,
    ckpt_free_list_allocator_if.slave  bus
);
    localparam int IDX_W  = $clog2(NUM_RESOURCES);
    localparam int CKPT_W = (NUM_CKPTS > 1) ? $clog2(NUM_CKPTS) : 1;
    localparam int CNT_W  = IDX_W + 1;
    localparam int RCNT_W = $clog2(NUM_REQUESTS + 1);
    localparam int CMP_W  = (RCNT_W > CNT_W) ? RCNT_W : CNT_W;

    function automatic logic [CNT_W-1:0] popcount_res(input logic [NUM_RESOURCES-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_RESOURCES; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [CMP_W-1:0] popcount_req(input logic [NUM_REQUESTS-1:0] v);
        logic [CMP_W-1:0] c;
        c = {CMP_W{1'b0}};
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            c = c + {{(CMP_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Scanning downward leaves the lowest set bit as the final answer.
    function automatic logic [IDX_W-1:0] lowest_free(input logic [NUM_RESOURCES-1:0] m);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int j = NUM_RESOURCES - 1; j >= 0; j--) begin
            if (m[j]) begin
                r = IDX_W'(j);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [NUM_RESOURCES-1:0]      avail_r;
    logic [CNT_W-1:0]              free_count_r;
    logic [NUM_RESOURCES-1:0]      ckpt_r [NUM_CKPTS];

    logic [CMP_W-1:0]              req_cnt_s;
    logic [NUM_RESOURCES-1:0]      work_s;
    logic [NUM_RESOURCES-1:0]      alloc_s;
    logic [IDX_W-1:0]              pick_s;
    logic [NUM_REQUESTS-1:0]       grant_valid_s;
    logic [NUM_REQUESTS*IDX_W-1:0] grant_idx_s;
    logic                          stall_s;
    logic [NUM_RESOURCES-1:0]      snap_s;
    logic                          restore_ok_s;
    logic [NUM_RESOURCES-1:0]      avail_next_s;

    // Grant path: requesters in ascending order take the lowest remaining free index.
    always_comb begin
        req_cnt_s     = popcount_req(bus.req);
        work_s        = avail_r;
        alloc_s       = {NUM_RESOURCES{1'b0}};
        pick_s        = {IDX_W{1'b0}};
        grant_valid_s = {NUM_REQUESTS{1'b0}};
        grant_idx_s   = {(NUM_REQUESTS*IDX_W){1'b0}};
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = bus.ckpt_restore | (req_cnt_s > CMP_W'(free_count_r));
        end
        if (!reset && !stall_s) begin
            for (int i = 0; i < NUM_REQUESTS; i++) begin
                if (bus.req[i]) begin
                    pick_s                          = lowest_free(work_s);
                    grant_valid_s[i]                = 1'b1;
                    grant_idx_s[i*IDX_W +: IDX_W]   = pick_s;
                    work_s[pick_s]                  = 1'b0;
                    alloc_s[pick_s]                 = 1'b1;
                end else begin
                    grant_valid_s[i] = 1'b0;
                end
            end
        end else begin
            alloc_s = {NUM_RESOURCES{1'b0}};
        end
    end

    // Next free mask; a restore replaces the live mask, a slot id beyond NUM_CKPTS keeps it.
    always_comb begin
        snap_s       = (avail_r & ~alloc_s) | bus.clear;
        restore_ok_s = int'(bus.ckpt_restore_id) < NUM_CKPTS;
        if (bus.ckpt_restore && restore_ok_s) begin
            avail_next_s = ckpt_r[bus.ckpt_restore_id] | bus.clear;
        end else begin
            avail_next_s = snap_s;
        end
    end

    // Live mask, its popcount, and checkpoint slots that keep absorbing retirements.
    always_ff @(posedge clock) begin
        if (reset) begin
            avail_r      <= INITIAL_AVAIL_MASK;
            free_count_r <= popcount_res(INITIAL_AVAIL_MASK);
            for (int k = 0; k < NUM_CKPTS; k++) begin
                ckpt_r[k] <= INITIAL_AVAIL_MASK;
            end
        end else begin
            avail_r      <= avail_next_s;
            free_count_r <= popcount_res(avail_next_s);
            for (int k = 0; k < NUM_CKPTS; k++) begin
                if (bus.ckpt_save && !bus.ckpt_restore && (CKPT_W'(k) == bus.ckpt_save_id)) begin
                    ckpt_r[k] <= snap_s;
                end else begin
                    ckpt_r[k] <= ckpt_r[k] | bus.clear;
                end
            end
        end
    end

    assign bus.grant_valid = grant_valid_s;
    assign bus.grant_idx   = grant_idx_s;
    assign bus.stall       = stall_s;
    assign bus.free_count  = free_count_r;
endmodule

// File: tb/tb_ckpt_free_list_allocator.sv
// Directed and random checks of ckpt_free_list_allocator against a set-based reference model.
module tb_ckpt_free_list_allocator;
    localparam int N  = 64;
    localparam int R  = 3;
    localparam int C  = 4;
    localparam int IW = 6;
    localparam int CW = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ckpt_free_list_allocator_if #(.NUM_RESOURCES(N), .NUM_REQUESTS(R), .NUM_CKPTS(C)) bus ();

    ckpt_free_list_allocator #(
        .NUM_RESOURCES(N), .NUM_REQUESTS(R), .NUM_CKPTS(C), .INITIAL_AVAIL_MASK({N{1'b1}})
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int check_cnt = 0;
    int error_cnt = 0;

    logic [N-1:0]    m_avail;
    logic [N-1:0]    m_ckpt [C];
    logic [R-1:0]    o_gv;
    logic [R*IW-1:0] o_gi;
    logic            o_stall;
    logic [IW:0]     o_fc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ones(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [N-1:0] bitn(input int i);
        logic [N-1:0] m;
        m = {N{1'b0}};
        m[i] = 1'b1;
        return m;
    endfunction

    task automatic drive(input logic [R-1:0] r, input logic [N-1:0] clr, input logic sv,
                         input logic [CW-1:0] sid, input logic rs, input logic [CW-1:0] rid);
        bus.req             = r;
        bus.clear           = clr;
        bus.ckpt_save       = sv;
        bus.ckpt_save_id    = sid;
        bus.ckpt_restore    = rs;
        bus.ckpt_restore_id = rid;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(3'b111, {N{1'b0}}, 1'b0, 2'd0, 1'b0, 2'd0);
        @(negedge clock);
        check_eq("rst_grant_valid", 64'(bus.grant_valid), 64'd0);
        check_eq("rst_grant_idx", 64'(bus.grant_idx), 64'd0);
        check_eq("rst_stall", 64'(bus.stall), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_avail = {N{1'b1}};
        for (int k = 0; k < C; k++) m_ckpt[k] = {N{1'b1}};
    endtask

    // One cycle: predict from the free set, compare, then advance the model.
    task automatic step(input logic [R-1:0] r, input logic [N-1:0] clr, input logic sv,
                        input logic [CW-1:0] sid, input logic rs, input logic [CW-1:0] rid);
        logic [N-1:0]    taken;
        logic [N-1:0]    nxt;
        logic [R-1:0]    e_gv;
        logic [R*IW-1:0] e_gi;
        logic            e_stall;
        int              n;
        int              fc;
        drive(r, clr, sv, sid, rs, rid);
        taken = {N{1'b0}};
        e_gv  = {R{1'b0}};
        e_gi  = {(R*IW){1'b0}};
        n = 0;
        for (int i = 0; i < R; i++) n += int'(r[i]);
        fc = ones(m_avail);
        e_stall = rs || (n > fc);
        if (!e_stall) begin
            for (int i = 0; i < R; i++) begin
                if (r[i]) begin
                    for (int j = 0; j < N; j++) begin
                        if (m_avail[j] && !taken[j]) begin
                            e_gi[i*IW +: IW] = IW'(j);
                            taken[j] = 1'b1;
                            break;
                        end
                    end
                    e_gv[i] = 1'b1;
                end
            end
        end
        @(negedge clock);
        o_gv    = bus.grant_valid;
        o_gi    = bus.grant_idx;
        o_stall = bus.stall;
        o_fc    = bus.free_count;
        check_eq("stall", 64'(o_stall), 64'(e_stall));
        check_eq("grant_valid", 64'(o_gv), 64'(e_gv));
        check_eq("grant_idx", 64'(o_gi), 64'(e_gi));
        check_eq("free_count", 64'(o_fc), 64'(fc));
        if (rs) nxt = m_ckpt[rid] | clr;
        else    nxt = (m_avail & ~taken) | clr;
        for (int k = 0; k < C; k++) m_ckpt[k] = m_ckpt[k] | clr;
        if (sv && !rs) m_ckpt[sid] = (m_avail & ~taken) | clr;
        m_avail = nxt;
        @(posedge clock);
        #1;
    endtask

    localparam logic [N-1:0] Z = {N{1'b0}};

    initial begin
        logic [N-1:0] clr;
        do_reset();

        // Fresh pool: three requests get 0,1,2.
        step(3'b111, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t1_idx", 64'(o_gi), 64'({6'd2, 6'd1, 6'd0}));
        step(3'b000, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t1_fc", 64'(o_fc), 64'd61);

        // Drain to empty, then free only index 7.
        for (int i = 0; i < 20; i++) step(3'b111, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        step(3'b001, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        step(3'b001, bitn(7), 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t3_empty_stall", 64'(o_stall), 64'd1);
        step(3'b011, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t2_stall", 64'(o_stall), 64'd1);
        check_eq("t2_no_grant", 64'(o_gv), 64'd0);
        step(3'b010, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t2_gv", 64'(o_gv), 64'd2);
        check_eq("t2_idx", 64'(o_gi[11:6]), 64'd7);

        // Empty pool, clear 4: no same-cycle grant, granted next cycle.
        step(3'b001, bitn(4), 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t3_same_cycle", 64'(o_gv), 64'd0);
        step(3'b001, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t3_fc", 64'(o_fc), 64'd1);
        check_eq("t3_idx", 64'(o_gi[5:0]), 64'd4);

        // Repeated clear of an already-free index.
        step(3'b000, bitn(10), 1'b0, 2'd0, 1'b0, 2'd0);
        step(3'b000, bitn(10), 1'b0, 2'd0, 1'b0, 2'd0);
        step(3'b000, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t4_fc", 64'(o_fc), 64'd1);

        // Checkpoint save with a grant, more allocs, clear, restore.
        do_reset();
        step(3'b001, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        step(3'b001, Z, 1'b1, 2'd2, 1'b0, 2'd0);
        step(3'b011, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        step(3'b000, bitn(1), 1'b0, 2'd0, 1'b0, 2'd0);
        step(3'b001, Z, 1'b0, 2'd0, 1'b1, 2'd2);
        check_eq("t5_restore_stall", 64'(o_stall), 64'd1);
        check_eq("t5_restore_nogrant", 64'(o_gv), 64'd0);
        step(3'b000, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t5_fc", 64'(o_fc), 64'd63);

        // Save and restore together: the save must be ignored.
        step(3'b111, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        step(3'b000, bitn(1), 1'b1, 2'd1, 1'b1, 2'd3);
        step(3'b000, Z, 1'b0, 2'd0, 1'b1, 2'd1);
        step(3'b000, Z, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t6_fc", 64'(o_fc), 64'd64);

        // Random traffic with occasional mid-run resets.
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                clr = Z;
                if ($urandom_range(0, 3) == 0)
                    clr = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & ~m_avail;
                step(3'($urandom_range(0, 7)), clr, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end
endmodule
